// File: rtl/fpcvt_sched_pkg.sv
// Shared widths, saturation limits and the packed float result type for
// the fpcvt_sched block.
package fpcvt_pkg;

    localparam int IN_W  = 12;
    localparam int E_W   = 3;
    localparam int F_W   = 4;
    localparam int E_MAX = 7;
    localparam int F_MAX = 15;

    typedef struct packed {
        logic           s;
        logic [E_W-1:0] e;
        logic [F_W-1:0] f;
    } fp_t;

endpackage

// File: rtl/fpcvt_sched_if.sv
// Request/result bus of fpcvt_sched: N valid/ready sample ports in, one
// tagged float result port out.
interface fpcvt_sched_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]                  req_valid;
    logic [fpcvt_pkg::IN_W*N-1:0]  req_data;
    logic [N-1:0]                  req_ready;
    logic                          out_valid;
    logic                          out_ready;
    logic [IDW-1:0]                out_id;
    logic                          out_s;
    logic [fpcvt_pkg::E_W-1:0]     out_e;
    logic [fpcvt_pkg::F_W-1:0]     out_f;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_id, out_s, out_e, out_f
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_id, out_s, out_e, out_f
    );
endinterface

// File: rtl/fpcvt_sched_fpcvt.sv
// Combinational 12-bit two's-complement to (S, E, F) converter with
// half-up rounding; value = (-1)^S * F * 2^E.
module fpcvt_sched_fpcvt
    import fpcvt_pkg::*;
(
    input  logic [IN_W-1:0] i_x,
    output fp_t             o_fp
);
    logic            w_sign;
    logic [IN_W-1:0] w_mag;
    logic [3:0]      w_pos;
    logic [3:0]      w_shift;
    logic [4:0]      w_win;
    logic [4:0]      w_sum;
    logic [3:0]      w_e;
    logic [3:0]      w_f;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        w_sign = i_x[IN_W-1];
        w_mag  = w_sign ? -i_x : i_x;
        w_pos  = 4'd0;
        for (int i = 0; i < IN_W; i++) begin
            if (w_mag[i]) w_pos = 4'(i);
        end
        w_shift = (w_pos > 4'd3) ? w_pos - 4'd3 : 4'd0;
        // Window holds the 4 kept bits plus the rounding bit below them;
        // magnitude 2048 (from -2048) lands on shift 8 and saturates below.
        w_win = 5'({w_mag, 1'b0} >> w_shift);
        w_sum = {1'b0, w_win[4:1]} + {4'b0000, w_win[0]};
        w_e   = w_sum[4] ? w_shift + 4'd1 : w_shift;
        w_f   = w_sum[4] ? 4'd8 : w_sum[3:0];

        o_fp.s = w_sign;
        if (w_e > 4'(E_MAX)) begin
            o_fp.e = E_W'(E_MAX);
            o_fp.f = F_W'(F_MAX);
        end else begin
            o_fp.e = w_e[E_W-1:0];
            o_fp.f = w_f;
        end
    end
endmodule

// File: rtl/fpcvt_sched.sv
// Round-robin scheduler sharing one FPCVT among N requesters through a
// two-stage valid/ready pipeline with full output backpressure.
module fpcvt_sched
    import fpcvt_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    fpcvt_sched_if.slave bus
);
    logic [IDW-1:0]  r_ptr;
    logic            r_s1_valid;
    logic [IDW-1:0]  r_s1_id;
    logic [IN_W-1:0] r_s1_data;
    logic            r_out_valid;
    logic [IDW-1:0]  r_out_id;
    fp_t             r_out;

    logic            w_s2_free;
    logic            w_s1_free;
    logic            w_found;
    logic            w_accept;
    int              w_idx;
    logic [IDW-1:0]  w_gnt_id;
    logic [IDW-1:0]  w_ptr_next;
    logic [N-1:0]    w_req_ready;
    fp_t             w_cvt;

    assign w_s2_free = !r_out_valid || bus.out_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;

    // Priority search starting at the round-robin pointer.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(r_ptr) + k) % N;
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[IDW-1:0];
            end
        end
    end

    assign w_accept   = w_found && w_s1_free;
    assign w_ptr_next = (w_gnt_id == IDW'(N - 1)) ? '0 : w_gnt_id + IDW'(1);

    always_comb begin
        w_req_ready = '0;
        for (int i = 0; i < N; i++) begin
            w_req_ready[i] = w_accept && (w_gnt_id == IDW'(i));
        end
    end

    // Flops are already held in reset, so only the visible ready needs masking.
    assign bus.req_ready = w_req_ready & ~{N{rst}};

    fpcvt_sched_fpcvt u_fpcvt (
        .i_x  (r_s1_data),
        .o_fp (w_cvt)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_id     <= '0;
            r_s1_data   <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out       <= '0;
        end else begin
            if (w_accept) r_ptr <= w_ptr_next;
            if (w_s1_free) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_id   <= w_gnt_id;
                    r_s1_data <= bus.req_data[IN_W*w_gnt_id +: IN_W];
                end
            end
            if (w_s2_free) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_id <= r_s1_id;
                    r_out    <= w_cvt;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_id    = r_out_id;
    assign bus.out_s     = r_out.s;
    assign bus.out_e     = r_out.e;
    assign bus.out_f     = r_out.f;
endmodule

// File: tb/tb_fpcvt_sched.sv
// Self-checking bench for fpcvt_sched: directed phases plus random traffic
// against a queue-based transaction model and an arithmetic converter model.
module tb_fpcvt_sched;
    import fpcvt_pkg::*;

    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    typedef struct {
        int              id;
        logic [IN_W-1:0] data;
        int              acc;
    } item_t;

    logic clk;
    logic rst;

    fpcvt_sched_if #(.N(N)) bus ();

    fpcvt_sched #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_chk;
    int    n_err;
    int    m_ptr;
    int    n_edges;
    item_t q[$];
    int    acc_ids[$];
    int    obs[$];

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_chk++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Converter model from the arithmetic definition of the format.
    function automatic logic [7:0] ref_cvt(input logic [IN_W-1:0] x);
        int   v, m, p, e, f;
        logic s;
        v = int'($signed(x));
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 8'h00;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        e = (p > 3) ? p - 3 : 0;
        f = (e > 0) ? (m + (1 << (e - 1))) >> e : m;
        if (f == 16) begin
            f = 8;
            e++;
        end
        if (e > 7) begin
            e = 7;
            f = 15;
        end
        return {s, 3'(e), 4'(f)};
    endfunction

    function automatic int enc(input int id, input int s, input int e, input int f);
        return id * 256 + s * 128 + e * 16 + f;
    endfunction

    function automatic logic [IN_W*N-1:0] rand_data();
        logic [IN_W*N-1:0] d;
        for (int i = 0; i < N; i++) d[IN_W*i +: IN_W] = IN_W'($urandom());
        return d;
    endfunction

    function automatic logic [IN_W*N-1:0] put(input int slot, input logic [IN_W-1:0] x);
        logic [IN_W*N-1:0] d;
        d = rand_data();
        d[IN_W*slot +: IN_W] = x;
        return d;
    endfunction

    // One clock cycle: drive at negedge, check 1 time unit later, update model at posedge.
    task automatic step(input logic [N-1:0] v, input logic [IN_W*N-1:0] d, input logic ordy);
        logic [N-1:0] exp_rdy;
        logic [7:0]   r;
        int           g;
        bit           head_vis;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_data  = d;
        bus.out_ready = ordy;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        exp_rdy = '0;
        if (g >= 0 && (q.size() < 2 || ordy)) exp_rdy[g] = 1'b1;
        head_vis = (q.size() > 0) && (n_edges >= q[0].acc + 2);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(head_vis));
        if (head_vis) begin
            r = ref_cvt(q[0].data);
            chk("out_id", 32'(bus.out_id), 32'(q[0].id));
            chk("out_s", 32'(bus.out_s), 32'(r[7]));
            chk("out_e", 32'(bus.out_e), 32'(r[6:4]));
            chk("out_f", 32'(bus.out_f), 32'(r[3:0]));
        end
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) acc_ids.push_back(i);
        end
        if (bus.out_valid && ordy)
            obs.push_back(enc(int'(bus.out_id), int'(bus.out_s), int'(bus.out_e), int'(bus.out_f)));
        @(posedge clk);
        if (head_vis && ordy) void'(q.pop_front());
        if (exp_rdy != '0) begin
            q.push_back('{id: g, data: d[IN_W*g +: IN_W], acc: n_edges});
            m_ptr = (g + 1) % N;
        end
        n_edges++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step('0, rand_data(), 1'b1);
    endtask

    initial begin
        int exp_tbl[$];
        int start;

        n_chk   = 0;
        n_err   = 0;
        m_ptr   = 0;
        n_edges = 0;
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_out_id", 32'(bus.out_id), 32'h0);
        chk("reset_out_sef", {29'h0, bus.out_s, 2'b00} | 32'({bus.out_e, bus.out_f}), 32'h0);
        bus.req_valid = '0;
        rst = 1'b0;

        // Single requester, rounding around 44..47.
        obs.delete();
        step(4'b0001, put(0, 12'd44), 1'b1);
        step(4'b0001, put(0, 12'd45), 1'b1);
        step(4'b0001, put(0, 12'd46), 1'b1);
        step(4'b0001, put(0, 12'd47), 1'b1);
        idle(3);
        exp_tbl = '{enc(0, 0, 2, 11), enc(0, 0, 2, 11), enc(0, 0, 2, 12), enc(0, 0, 2, 12)};
        chk("seq_count", 32'(obs.size()), 32'(exp_tbl.size()));
        for (int i = 0; i < exp_tbl.size(); i++)
            if (i < obs.size()) chk("seq_result", 32'(obs[i]), 32'(exp_tbl[i]));

        // Saturation and corner values.
        obs.delete();
        step(4'b0001, put(0, 12'h800), 1'b1);
        step(4'b0001, put(0, 12'h7FF), 1'b1);
        step(4'b0001, put(0, 12'h000), 1'b1);
        step(4'b0001, put(0, 12'hFD2), 1'b1);
        step(4'b0001, put(0, 12'h001), 1'b1);
        idle(3);
        exp_tbl = '{enc(0, 1, 7, 15), enc(0, 0, 7, 15), enc(0, 0, 0, 0), enc(0, 1, 2, 12), enc(0, 0, 0, 1)};
        chk("corner_count", 32'(obs.size()), 32'(exp_tbl.size()));
        for (int i = 0; i < exp_tbl.size(); i++)
            if (i < obs.size()) chk("corner_result", 32'(obs[i]), 32'(exp_tbl[i]));

        // Fairness: all valid, one grant per cycle in rotating order.
        acc_ids.delete();
        start = m_ptr;
        for (int i = 0; i < 12; i++) step('1, rand_data(), 1'b1);
        idle(3);
        chk("rr_count", 32'(acc_ids.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            if (i < acc_ids.size()) chk("rr_order", 32'(acc_ids[i]), 32'((start + i) % N));

        // Backpressure: two acceptances fill the pipe, then drain in order.
        acc_ids.delete();
        for (int i = 0; i < 5; i++) step('1, rand_data(), 1'b0);
        chk("bp_accepts", 32'(acc_ids.size()), 32'd2);
        obs.delete();
        idle(4);
        chk("bp_drained", 32'(obs.size()), 32'd2);

        // Sparse requesters 1 and 3 from ptr=2.
        step(4'b0010, rand_data(), 1'b1);
        acc_ids.delete();
        for (int i = 0; i < 4; i++) step(4'b1010, rand_data(), 1'b1);
        idle(3);
        exp_tbl = '{3, 1, 3, 1};
        chk("sparse_count", 32'(acc_ids.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < acc_ids.size()) chk("sparse_order", 32'(acc_ids[i]), 32'(exp_tbl[i]));

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++)
            step(N'($urandom_range(0, (1 << N) - 1)), rand_data(), $urandom_range(0, 3) != 0);
        idle(3);

        // Asynchronous reset with a full pipeline.
        for (int i = 0; i < 3; i++) step('1, rand_data(), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_async_req_ready", 32'(bus.req_ready), 32'h0);
        q.delete();
        m_ptr = 0;
        @(negedge clk);
        bus.req_valid = '0;
        rst = 1'b0;
        acc_ids.delete();
        for (int i = 0; i < 4; i++) step('1, rand_data(), 1'b1);
        idle(3);
        chk("rst_first_grant", (acc_ids.size() > 0) ? 32'(acc_ids[0]) : 32'hFFFF_FFFF, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fpcvt_sched.md
# fpcvt_sched

Round-robin scheduler that shares one combinational 12-bit two's-complement to floating-point converter (FPCVT) among N requesters. Each requester offers a 12-bit sample over a valid/ready handshake; the block arbitrates, feeds the winner through a two-stage pipeline around the single FPCVT instance, and returns the sign/exponent/significand result tagged with the requester index over a valid/ready output port with full backpressure.

## Interface
- N, 4: number of requesters, 2..8.
- IDW, $clog2(N): width of the requester tag.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N  bit i: requester i offers a sample.
- req_data  input  12*N  requester i sample in bits [12i+11:12i], two's complement.
- req_ready  output  N  bit i: sample i accepted this cycle; at most one bit set.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_id  output  IDW  index of the requester that produced the result.
- out_s  output  1  sign.
- out_e  output  3  exponent.
- out_f  output  4  significand; value = (-1)^S * F * 2^E.

## Operation
- Arbitration: round-robin pointer ptr (IDW bits, reset 0). Grant goes to the first i with req_valid[i], searching ptr, ptr+1, … mod N. After an accepted handshake with requester g, ptr becomes (g+1) mod N. ptr is unchanged when nothing is accepted.
- req_ready[g] = grant[g] & s1_free. req_ready is combinational from req_valid, ptr and pipeline state. It never asserts for a requester whose req_valid is low.
- Stage 1 register: {s1_valid, s1_id, s1_data}. Loads the granted sample on handshake.
- Stage 2 register: {out_valid, out_id, out_s, out_e, out_f}. Loads the FPCVT result of stage 1.
- Pipeline control:
  - s2_free = !out_valid | out_ready.
  - s1_free = !s1_valid | s2_free.
  - Stage 2 loads when s1_valid & s2_free.
  - out_valid clears when out_ready is high and stage 1 is empty.
- FPCVT conversion rules (embedded sub-module):
  - Sign-magnitude conversion.
  - Exponent = 8 − leading zeros of the magnitude, clamped to 0..7.
  - F = the 4 bits starting at the leading one.
  - Round half-up on the next lower bit. If F overflows to 16, F=8 and E+1. If E would exceed 7, saturate to E=7, F=15.
  - −2048 saturates to S=1, E=7, F=15.
  - 0 gives S=0, E=0, F=0.
- Results leave in acceptance order. No drops and no duplicates.
- Output fields are held stable while out_valid & !out_ready.

## Timing
- Reset values: ptr=0, s1_valid=0, out_valid=0, out_id=0, out_s=0, out_e=0, out_f=0. req_ready is 0 while rst is high.
- Latency: a sample accepted at edge k appears with out_valid=1 after edge k+1, and can be consumed at edge k+2.
- Throughput: one result per cycle while out_ready stays high.
- Stall: with out_ready low, the pipeline fills. Two samples are held and req_ready drops to 0 in the cycle after the second acceptance.
- Simultaneous accept and drain: if out_ready=1 and the pipeline is full, stage 2 takes stage 1 and stage 1 takes a new sample in the same edge.
- Reset mid-operation clears every in-flight sample immediately. Requesters must re-offer.

## Structure
- Package fpcvt_pkg:
  - width constants IN_W=12, E_W=3, F_W=4;
  - saturation constants E_MAX=7, F_MAX=15;
  - a packed typedef fp_t {s, e, f}.
- One sub-module: FPCVT (combinational converter), instantiated once between stage 1 and stage 2.
- The arbiter priority search stays inline.

## Test plan
- Single requester 0 sends 44, 45, 46, 47 with out_ready=1. Required outputs, each 2 cycles after its handshake:
  - 44 → (0,2,11), 45 → (0,2,11), 46 → (0,2,12), 47 → (0,2,12);
  - out_id=0 for all.
- Saturation and corners:
  - −2048 → (1,7,15);
  - 2047 → (0,7,15);
  - 0 → (0,0,0);
  - −46 → (1,2,12);
  - 1 → (0,0,1).
- Round-robin fairness: all four requesters valid continuously with out_ready=1. Grants follow 0,1,2,3,0,…, and each requester sees a ready pulse every 4th cycle.
- Backpressure: hold out_ready=0 for 5 cycles with all requesters valid.
  - Exactly 2 acceptances occur, then req_ready stays 0.
  - Output is held stable.
  - On release, results drain in order with no loss.
- Sparse requests: only requesters 1 and 3 valid, starting from ptr=2. Grant order is 3,1,3,1.
- Reset during a full pipeline: assert rst asynchronously mid-cycle.
  - out_valid drops before the next edge.
  - No stale result appears after rst is deasserted.
  - ptr restarts at 0.
